// File: rtl/dual_wb_sequencer.sv
// Register-file writeback sequencer for the dual-writeback add-and-classify op.
// Owns the single write port: normal writes pass through when idle.
module dual_wb_sequencer #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned CODE_ZERO = 1,
    parameter int unsigned CODE_NEG  = 2,
    parameter int unsigned CODE_POS  = 3,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] sum,
    input  logic              norm_we,
    input  logic [ADDR_W-1:0] norm_addr,
    input  logic [DATA_W-1:0] norm_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_data,
    output logic              stall,
    output logic              done,
    output logic [CNT_W-1:0]  op_count
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WR_RS = 2'd1;
    localparam logic [1:0] WR_RD = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] rs_q, rs_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic [DATA_W-1:0] code_q, code_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] code_now;
    logic              accept;

    // Sign test on the raw bit: the sum is two's complement with wrap-around.
    always_comb begin
        code_now = DATA_W'(CODE_POS);
        if (sum == '0)
            code_now = DATA_W'(CODE_ZERO);
        else if (sum[DATA_W-1])
            code_now = DATA_W'(CODE_NEG);
    end

    assign accept = op_valid && op_ready;

    always_comb begin
        state_d  = state_q;
        rs_d     = rs_q;
        rd_d     = rd_q;
        sum_d    = sum_q;
        code_d   = code_q;
        cnt_d    = cnt_q;
        op_ready = 1'b0;
        stall    = 1'b0;
        done     = 1'b0;
        rf_we    = 1'b0;
        rf_addr  = '0;
        rf_data  = '0;
        unique case (state_q)
            WR_RS: begin
                stall   = 1'b1;
                rf_we   = (rs_q != '0);
                rf_addr = rs_q;
                rf_data = sum_q;
                state_d = WR_RD;
            end
            WR_RD: begin
                stall   = 1'b1;
                done    = 1'b1;
                rf_we   = (rd_q != '0);
                rf_addr = rd_q;
                rf_data = code_q;
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = IDLE;
            end
            default: begin
                op_ready = 1'b1;
                rf_we    = norm_we;
                rf_addr  = norm_addr;
                rf_data  = norm_data;
                state_d  = IDLE;
                if (accept) begin
                    rs_d    = rs_addr;
                    rd_d    = rd_addr;
                    sum_d   = sum;
                    code_d  = code_now;
                    state_d = WR_RS;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rs_q    <= '0;
            rd_q    <= '0;
            sum_q   <= '0;
            code_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rs_q    <= rs_d;
            rd_q    <= rd_d;
            sum_q   <= sum_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
        end
    end

    assign op_count = cnt_q;

endmodule

// File: tb/tb_dual_wb_sequencer.sv
// Directed bench for dual_wb_sequencer: each task drives one scenario
// on the falling edge and checks outputs 1ns later.
module tb_dual_wb_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic        op_ready;
    logic [4:0]  rs_addr;
    logic [4:0]  rd_addr;
    logic [31:0] sum;
    logic        norm_we;
    logic [4:0]  norm_addr;
    logic [31:0] norm_data;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic        stall;
    logic        done;
    logic [15:0] op_count;

    logic [31:0] rf_mem [32];
    int          n_pass;
    int          n_total;
    logic [15:0] exp_cnt;

    always #5 clk = ~clk;

    always @(posedge clk)
        if (rf_we) rf_mem[rf_addr] <= rf_data;

    dual_wb_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .rs_addr   (rs_addr),
        .rd_addr   (rd_addr),
        .sum       (sum),
        .norm_we   (norm_we),
        .norm_addr (norm_addr),
        .norm_data (norm_data),
        .rf_we     (rf_we),
        .rf_addr   (rf_addr),
        .rf_data   (rf_data),
        .stall     (stall),
        .done      (done),
        .op_count  (op_count)
    );

    task automatic idle_inputs();
        op_valid  = 1'b0;
        rs_addr   = '0;
        rd_addr   = '0;
        sum       = '0;
        norm_we   = 1'b0;
        norm_addr = '0;
        norm_data = '0;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_cnt = '0;
        norm_we = 1'b1; norm_addr = 5'd9; norm_data = 32'h55;
        #1;
        n_total++;
        if ({op_ready, stall, done} !== 3'b100)
            $display("FAIL reset_ctrl: got rdy/stall/done=%b want 100",
                     {op_ready, stall, done});
        else n_pass++;
        n_total++;
        if (op_count !== 16'd0)
            $display("FAIL reset_cnt: got %0d want 0", op_count);
        else n_pass++;
        n_total++;
        if ({rf_we, rf_addr, rf_data} !== {1'b1, 5'd9, 32'h55})
            $display("FAIL reset_pass: got we=%b a=%0d d=%h want 1/9/55",
                     rf_we, rf_addr, rf_data);
        else n_pass++;
        norm_we = 1'b0; norm_addr = '0; norm_data = '0;
        #1;
        n_total++;
        if (rf_we !== 1'b0)
            $display("FAIL reset_pass_off: got we=%b want 0", rf_we);
        else n_pass++;
    endtask

    task automatic test_basic();
        step();
        op_valid = 1'b1; rs_addr = 5'd5; rd_addr = 5'd6; sum = 32'h0;
        step();
        idle_inputs();
        #1;
        n_total++;
        if ({rf_we, rf_addr, rf_data, stall, op_ready, done}
            !== {1'b1, 5'd5, 32'h0, 1'b1, 1'b0, 1'b0})
            $display("FAIL basic_rs: got we=%b a=%0d d=%h st=%b rdy=%b dn=%b",
                     rf_we, rf_addr, rf_data, stall, op_ready, done);
        else n_pass++;
        step();
        n_total++;
        if ({rf_we, rf_addr, rf_data, done} !== {1'b1, 5'd6, 32'd1, 1'b1})
            $display("FAIL basic_rd: got we=%b a=%0d d=%h dn=%b want 1/6/1/1",
                     rf_we, rf_addr, rf_data, done);
        else n_pass++;
        exp_cnt++;
        step();
        n_total++;
        if ({op_count, stall, op_ready} !== {exp_cnt, 1'b0, 1'b1})
            $display("FAIL basic_end: got cnt=%0d st=%b rdy=%b want %0d/0/1",
                     op_count, stall, op_ready, exp_cnt);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int stalls;
        stalls = 0;
        op_valid = 1'b1; rs_addr = 5'd1; rd_addr = 5'd2; sum = 32'hFFFF_FFF0;
        #1;
        n_total++;
        if (op_ready !== 1'b1)
            $display("FAIL b2b_acc1: got rdy=%b want 1", op_ready);
        else n_pass++;
        if (stall) stalls++;
        step();
        rs_addr = 5'd3; rd_addr = 5'd4; sum = 32'h0000_0009;
        #1;
        if (stall) stalls++;
        n_total++;
        if ({rf_addr, rf_data} !== {5'd1, 32'hFFFF_FFF0})
            $display("FAIL b2b_rs1: got a=%0d d=%h want 1/fffffff0",
                     rf_addr, rf_data);
        else n_pass++;
        step();
        if (stall) stalls++;
        n_total++;
        if ({rf_addr, rf_data, done} !== {5'd2, 32'd2, 1'b1})
            $display("FAIL b2b_code1: got a=%0d d=%h dn=%b want 2/2/1",
                     rf_addr, rf_data, done);
        else n_pass++;
        exp_cnt++;
        step();
        if (stall) stalls++;
        n_total++;
        if (op_ready !== 1'b1)
            $display("FAIL b2b_acc2: got rdy=%b want 1", op_ready);
        else n_pass++;
        step();
        op_valid = 1'b0;
        #1;
        if (stall) stalls++;
        n_total++;
        if ({rf_addr, rf_data} !== {5'd3, 32'd9})
            $display("FAIL b2b_rs2: got a=%0d d=%h want 3/9", rf_addr, rf_data);
        else n_pass++;
        step();
        if (stall) stalls++;
        n_total++;
        if ({rf_addr, rf_data, done} !== {5'd4, 32'd3, 1'b1})
            $display("FAIL b2b_code2: got a=%0d d=%h dn=%b want 4/3/1",
                     rf_addr, rf_data, done);
        else n_pass++;
        exp_cnt++;
        step();
        if (stall) stalls++;
        n_total++;
        if (stalls !== 4)
            $display("FAIL b2b_stall: got %0d stall cycles want 4", stalls);
        else n_pass++;
        n_total++;
        if (op_count !== exp_cnt)
            $display("FAIL b2b_cnt: got %0d want %0d", op_count, exp_cnt);
        else n_pass++;
        idle_inputs();
    endtask

    task automatic test_same_reg();
        step();
        op_valid = 1'b1; rs_addr = 5'd7; rd_addr = 5'd7; sum = 32'h8000_0000;
        step();
        idle_inputs();
        #1;
        n_total++;
        if ({rf_we, rf_addr, rf_data} !== {1'b1, 5'd7, 32'h8000_0000})
            $display("FAIL same_rs: got we=%b a=%0d d=%h want 1/7/80000000",
                     rf_we, rf_addr, rf_data);
        else n_pass++;
        step();
        n_total++;
        if ({rf_we, rf_addr, rf_data} !== {1'b1, 5'd7, 32'd2})
            $display("FAIL same_rd: got we=%b a=%0d d=%h want 1/7/2",
                     rf_we, rf_addr, rf_data);
        else n_pass++;
        exp_cnt++;
        step();
        n_total++;
        if (rf_mem[7] !== 32'd2)
            $display("FAIL same_final: got reg7=%h want 2", rf_mem[7]);
        else n_pass++;
    endtask

    task automatic test_zero_idx();
        op_valid = 1'b1; rs_addr = 5'd0; rd_addr = 5'd0; sum = 32'd5;
        step();
        idle_inputs();
        #1;
        n_total++;
        if ({rf_we, stall} !== 2'b01)
            $display("FAIL zero_rs: got we=%b st=%b want 0/1", rf_we, stall);
        else n_pass++;
        step();
        n_total++;
        if ({rf_we, done} !== 2'b01)
            $display("FAIL zero_rd: got we=%b dn=%b want 0/1", rf_we, done);
        else n_pass++;
        exp_cnt++;
        step();
        n_total++;
        if (op_count !== exp_cnt)
            $display("FAIL zero_cnt: got %0d want %0d", op_count, exp_cnt);
        else n_pass++;
    endtask

    task automatic test_norm_with_op();
        op_valid = 1'b1; rs_addr = 5'd10; rd_addr = 5'd11; sum = 32'h7FFF_FFFF;
        norm_we = 1'b1; norm_addr = 5'd3; norm_data = 32'hAB;
        #1;
        n_total++;
        if ({rf_we, rf_addr, rf_data, op_ready} !== {1'b1, 5'd3, 32'hAB, 1'b1})
            $display("FAIL norm_pass: got we=%b a=%0d d=%h rdy=%b want 1/3/ab/1",
                     rf_we, rf_addr, rf_data, op_ready);
        else n_pass++;
        step();
        idle_inputs();
        norm_we = 1'b1; norm_addr = 5'd12; norm_data = 32'hDEAD;
        #1;
        n_total++;
        if (rf_mem[3] !== 32'hAB)
            $display("FAIL norm_reg3: got %h want ab", rf_mem[3]);
        else n_pass++;
        n_total++;
        if ({rf_addr, rf_data} !== {5'd10, 32'h7FFF_FFFF})
            $display("FAIL norm_rs: got a=%0d d=%h want 10/7fffffff",
                     rf_addr, rf_data);
        else n_pass++;
        step();
        n_total++;
        if ({rf_addr, rf_data, done} !== {5'd11, 32'd3, 1'b1})
            $display("FAIL norm_rd: got a=%0d d=%h dn=%b want 11/3/1",
                     rf_addr, rf_data, done);
        else n_pass++;
        exp_cnt++;
        step();
        n_total++;
        if ({rf_we, rf_addr, rf_data} !== {1'b1, 5'd12, 32'hDEAD})
            $display("FAIL norm_held: got we=%b a=%0d d=%h want 1/12/dead",
                     rf_we, rf_addr, rf_data);
        else n_pass++;
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        step();
        op_valid = 1'b1; rs_addr = 5'd13; rd_addr = 5'd14; sum = 32'd1;
        step();
        idle_inputs();
        reset = 1'b1;
        #1;
        n_total++;
        if ({rf_we, rf_addr} !== {1'b1, 5'd13})
            $display("FAIL rst_mid_rs: got we=%b a=%0d want 1/13",
                     rf_we, rf_addr);
        else n_pass++;
        step();
        reset = 1'b0;
        #1;
        exp_cnt = '0;
        n_total++;
        if ({rf_we, done, stall, op_ready} !== 4'b0001)
            $display("FAIL rst_mid_ctl: got we/dn/st/rdy=%b want 0001",
                     {rf_we, done, stall, op_ready});
        else n_pass++;
        n_total++;
        if (op_count !== exp_cnt)
            $display("FAIL rst_mid_cnt: got %0d want 0", op_count);
        else n_pass++;
        step();
        n_total++;
        if ({rf_we, done, stall} !== 3'b000)
            $display("FAIL rst_mid_quiet: got we/dn/st=%b want 000",
                     {rf_we, done, stall});
        else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        exp_cnt = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_same_reg();
        test_zero_idx();
        test_norm_with_op();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
